// File: rtl/ws2812_pkg.sv
// ws2812_pkg: timing defaults, FSM and error encodings
// shared by the WS2812 receive and transmit sides.
package ws2812_pkg;

    localparam int DEF_T_MIN_HIGH = 15;
    localparam int DEF_T_THRESH   = 60;
    localparam int DEF_T_MAX_HIGH = 110;
    localparam int DEF_T_RESET    = 5000;
    localparam int WORD_BITS      = 24;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2,
        ERR_OVF   = 2'd3
    } err_code_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-word write port and frame/error status
// from the WS2812 receiver to its consumer.
interface ws2812_rx_if #(
    parameter int ADDR_BIT = 5
) ();

    logic                wr_en;
    logic [ADDR_BIT-1:0] wr_address;
    logic [23:0]         wr_data;
    logic                frame_done;
    logic [ADDR_BIT-1:0] frame_words;
    logic                RST;
    logic                err;
    logic [1:0]          err_code;

    modport master (
        output wr_en, wr_address, wr_data,
        output frame_done, frame_words,
        output RST, err, err_code
    );

    modport slave (
        input wr_en, wr_address, wr_data,
        input frame_done, frame_words,
        input RST, err, err_code
    );

endinterface

// File: rtl/ws2812_pulse_meas.sv
// ws2812_pulse_meas: 2-flop DIN synchroniser, edge detect and
// saturating high/low duration counters on the synchronised line.
module ws2812_pulse_meas #(
    parameter int HI_W   = 7,
    parameter int LO_W   = 13,
    parameter int HI_SAT = 111,
    parameter int LO_SAT = 5000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din,
    output logic            rise,
    output logic            fall,
    output logic [HI_W-1:0] hi_cnt,
    output logic [LO_W-1:0] lo_cnt
);

    localparam logic [HI_W-1:0] HI_TOP = HI_W'(HI_SAT);
    localparam logic [LO_W-1:0] LO_TOP = LO_W'(LO_SAT);

    logic s1;
    logic din_s;
    logic din_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            din_s  <= 1'b0;
            din_d  <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            s1    <= din;
            din_s <= s1;
            din_d <= din_s;
            // each counter holds its final value for the edge cycle
            if (din_s) begin
                lo_cnt <= '0;
                if (hi_cnt != HI_TOP)
                    hi_cnt <= hi_cnt + 1'b1;
            end else begin
                hi_cnt <= '0;
                if (lo_cnt != LO_TOP)
                    lo_cnt <= lo_cnt + 1'b1;
            end
        end
    end

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ line decoder; classifies pulses, assembles
// 24-bit words MSB-first and reports frame end and protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int LED_NUM    = 16,
    parameter int ADDR_BIT   = $clog2(LED_NUM) + 1,
    parameter int T_MIN_HIGH = DEF_T_MIN_HIGH,
    parameter int T_THRESH   = DEF_T_THRESH,
    parameter int T_MAX_HIGH = DEF_T_MAX_HIGH,
    parameter int T_RESET    = DEF_T_RESET
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        DIN,
    ws2812_rx_if.master bus
);

    localparam int HI_W = $clog2(T_MAX_HIGH + 2);
    localparam int LO_W = $clog2(T_RESET + 1);

    localparam logic [HI_W-1:0] HI_MIN = HI_W'(T_MIN_HIGH);
    localparam logic [HI_W-1:0] HI_THR = HI_W'(T_THRESH);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(T_MAX_HIGH);
    localparam logic [LO_W-1:0] LO_TOP = LO_W'(T_RESET);
    localparam logic [ADDR_BIT-1:0] FULL = ADDR_BIT'(LED_NUM);
    localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

    logic            rise;
    logic            fall;
    logic [HI_W-1:0] hi_cnt;
    logic [LO_W-1:0] lo_cnt;

    rx_state_e state;
    rx_state_e nxt;

    logic        ev_bit;
    logic        ev_short;
    logic        ev_long;
    logic        ev_end;
    logic        bit_val;
    logic [22:0] shreg;
    logic [4:0]  bit_cnt;
    logic        ovf;

    ws2812_pulse_meas #(
        .HI_W   (HI_W),
        .LO_W   (LO_W),
        .HI_SAT (T_MAX_HIGH + 1),
        .LO_SAT (T_RESET)
    ) u_meas (
        .clk    (clk100),
        .reset  (reset),
        .din    (DIN),
        .rise   (rise),
        .fall   (fall),
        .hi_cnt (hi_cnt),
        .lo_cnt (lo_cnt)
    );

    always_ff @(posedge clk100) begin
        if (reset)
            state <= ST_ARM;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_ARM:
                if (lo_cnt == LO_TOP)
                    nxt = rise ? ST_HIGH : ST_IDLE;
            ST_IDLE:
                if (rise)
                    nxt = ST_HIGH;
            ST_HIGH:
                if (fall)
                    nxt = (ev_short || ev_long) ? ST_ARM : ST_LOW;
            ST_LOW:
                if (rise)
                    nxt = ST_HIGH;
                else if (ev_end)
                    nxt = ST_IDLE;
            default:
                nxt = ST_ARM;
        endcase
    end

    always_comb begin
        ev_bit   = 1'b0;
        ev_short = 1'b0;
        ev_long  = 1'b0;
        ev_end   = 1'b0;
        bit_val  = (hi_cnt >= HI_THR);
        unique case (state)
            ST_HIGH:
                if (fall) begin
                    ev_short = (hi_cnt < HI_MIN);
                    ev_long  = (hi_cnt > HI_MAX);
                    ev_bit   = !ev_short && !ev_long;
                end
            ST_LOW:
                ev_end = (lo_cnt == LO_TOP);
            default: ;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            shreg           <= '0;
            bit_cnt         <= '0;
            ovf             <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.wr_address  <= '0;
            bus.wr_data     <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_words <= '0;
            bus.RST         <= 1'b0;
            bus.err         <= 1'b0;
            bus.err_code    <= ERR_NONE;
        end else begin
            bus.wr_en      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
            if (bus.wr_en)
                bus.wr_address <= bus.wr_address + 1'b1;
            if (rise)
                bus.RST <= 1'b0;
            else if (lo_cnt == LO_TOP)
                bus.RST <= 1'b1;
            // once the word store is full, data bits are dropped
            if (ev_bit && !ovf) begin
                shreg <= {shreg[21:0], bit_val};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (bus.wr_address == FULL) begin
                        ovf          <= 1'b1;
                        bus.err      <= 1'b1;
                        bus.err_code <= ERR_OVF;
                    end else begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_data <= {shreg, bit_val};
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (ev_short || ev_long) begin
                bus.err        <= 1'b1;
                bus.err_code   <= ev_short ? ERR_SHORT : ERR_LONG;
                bus.wr_address <= '0;
                bit_cnt        <= '0;
                ovf            <= 1'b0;
            end
            if (ev_end) begin
                bus.frame_done  <= 1'b1;
                bus.frame_words <= bus.wr_address;
                bus.wr_address  <= '0;
                bit_cnt         <= '0;
                ovf             <= 1'b0;
            end
        end
    end

endmodule
